// File: rtl/regfile_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// regfile_pkg - shared defaults, index-width helper, write priority
// Rev 1.0
// ------------------------------------------------------------------
package regfile_pkg;

  localparam int DEF_BITSIZE  = 64;
  localparam int DEF_REGSIZE  = 32;
  localparam int DEF_ZERO_REG = 31;

  // Load writeback (wr1) beats ALU writeback (wr0) on a same-register collision.
  localparam bit WR1_PRIO = 1'b1;

  function automatic int calc_aw(input int regsize);
    return (regsize > 1) ? $clog2(regsize) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ------------------------------------------------------------------
// rf_read_port - one combinational read port: zero-reg check, bypass, busy mask
// Rev 1.0
// ------------------------------------------------------------------
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int BITSIZE  = DEF_BITSIZE,
  parameter int REGSIZE  = DEF_REGSIZE,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int BYPASS   = 1,
  parameter int AW       = calc_aw(REGSIZE)
) (
  input  logic [AW-1:0]      sel,
  input  logic [BITSIZE-1:0] stored,
  input  logic               stored_busy,
  input  logic               wr0_q,
  input  logic [AW-1:0]      wr0_sel,
  input  logic [BITSIZE-1:0] wr0_data,
  input  logic               wr1_q,
  input  logic [AW-1:0]      wr1_sel,
  input  logic [BITSIZE-1:0] wr1_data,
  output logic [BITSIZE-1:0] data,
  output logic               busy
);

  logic valid;
  logic hit0;
  logic hit1;

  assign valid = (int'(sel) != ZERO_REG) && (int'(sel) < REGSIZE);
  assign hit0  = (BYPASS != 0) && wr0_q && (wr0_sel == sel);
  assign hit1  = (BYPASS != 0) && wr1_q && (wr1_sel == sel);

  always_comb begin
    data = stored;
    if (WR1_PRIO) begin
      if (hit1)      data = wr1_data;
      else if (hit0) data = wr0_data;
    end else begin
      if (hit0)      data = wr0_data;
      else if (hit1) data = wr1_data;
    end
    if (!valid) data = '0;
  end

  // A producer writing back this cycle resolves the hazard for the forwarded value.
  assign busy = valid && stored_busy && !(hit0 || hit1);

endmodule
`default_nettype wire

// File: rtl/regfile_mp_scoreboard.sv
`default_nettype none
// ------------------------------------------------------------------
// regfile_mp_scoreboard - multi-read, dual-write register file with busy scoreboard
// Rev 1.0
// ------------------------------------------------------------------
module regfile_mp_scoreboard
  import regfile_pkg::*;
#(
  parameter int BITSIZE  = DEF_BITSIZE,
  parameter int REGSIZE  = DEF_REGSIZE,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int BYPASS   = 1,
  localparam int AW      = calc_aw(REGSIZE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_RD*AW-1:0]      rd_sel,
  output logic [NUM_RD*BITSIZE-1:0] rd_data,
  output logic [NUM_RD-1:0]         rd_busy,
  input  logic                      wr0_en,
  input  logic [AW-1:0]             wr0_sel,
  input  logic [BITSIZE-1:0]        wr0_data,
  input  logic                      wr1_en,
  input  logic [AW-1:0]             wr1_sel,
  input  logic [BITSIZE-1:0]        wr1_data,
  input  logic                      rsv_en,
  input  logic [AW-1:0]             rsv_sel,
  output logic [AW:0]               busy_cnt
);

  logic [BITSIZE-1:0] mem [REGSIZE];
  logic [REGSIZE-1:0] busy;
  logic [REGSIZE-1:0] busy_nxt;
  logic               wr0_q;
  logic               wr1_q;
  logic               rsv_q;
  logic               same_wr;
  logic               wr0_eff;
  logic               wr1_eff;
  logic               inc;
  logic               dec0;
  logic               dec1;

  function automatic logic idx_ok(input logic [AW-1:0] s);
    return (int'(s) != ZERO_REG) && (int'(s) < REGSIZE);
  endfunction

  // Gating with rst also keeps the bypass path from leaking reset-cycle writes.
  assign wr0_q   = wr0_en && !rst && idx_ok(wr0_sel);
  assign wr1_q   = wr1_en && !rst && idx_ok(wr1_sel);
  assign rsv_q   = rsv_en && !rst && idx_ok(rsv_sel);
  assign same_wr = wr0_q && wr1_q && (wr0_sel == wr1_sel);
  assign wr0_eff = wr0_q && !(same_wr && WR1_PRIO);
  assign wr1_eff = wr1_q && !(same_wr && !WR1_PRIO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < REGSIZE; r++) mem[r] <= '0;
    end else begin
      if (wr0_eff) mem[wr0_sel] <= wr0_data;
      if (wr1_eff) mem[wr1_sel] <= wr1_data;
    end
  end

  always_comb begin
    busy_nxt = busy;
    for (int r = 0; r < REGSIZE; r++) begin
      if ((wr0_q && int'(wr0_sel) == r) || (wr1_q && int'(wr1_sel) == r)) busy_nxt[r] = 1'b0;
      if (rsv_q && int'(rsv_sel) == r) busy_nxt[r] = 1'b1;
    end
  end

  // Count only real busy transitions: a clear overridden by a same-cycle reserve is not one.
  assign inc  = rsv_q && !busy[rsv_sel];
  assign dec0 = wr0_q && busy[wr0_sel] && !(rsv_q && rsv_sel == wr0_sel);
  assign dec1 = wr1_q && busy[wr1_sel] && !(rsv_q && rsv_sel == wr1_sel) && !same_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= busy_cnt + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec0} - {{AW{1'b0}}, dec1};
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] sel;
    assign sel = rd_sel[k*AW +: AW];

    rf_read_port #(
      .BITSIZE  (BITSIZE),
      .REGSIZE  (REGSIZE),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS),
      .AW       (AW)
    ) u_port (
      .sel         (sel),
      .stored      (mem[sel]),
      .stored_busy (busy[sel]),
      .wr0_q       (wr0_q),
      .wr0_sel     (wr0_sel),
      .wr0_data    (wr0_data),
      .wr1_q       (wr1_q),
      .wr1_sel     (wr1_sel),
      .wr1_data    (wr1_data),
      .data        (rd_data[k*BITSIZE +: BITSIZE]),
      .busy        (rd_busy[k])
    );
  end

endmodule
`default_nettype wire

// File: doc/regfile_mp_scoreboard.md
Name: regfile_mp_scoreboard

Overview:
- Parametrised successor to the datapath register file.
- Provides NUM_RD asynchronous read ports and two synchronous write ports (ALU writeback and load writeback).
- A configurable hardwired-zero register and optional write-to-read bypass are included.
- A per-register busy scoreboard lets the pipelined datapath detect RAW hazards on operands whose producer has not yet written back.

Parameters:
- BITSIZE, 64, data width of each register.
- REGSIZE, 32, number of registers; AW = $clog2(REGSIZE).
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 31, index of the hardwired-zero register: reads return 0, writes are ignored, never busy.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads; 0 = reads see only stored state.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- rd_sel  in  NUM_RD*AW  read selects; port k uses bits [k*AW +: AW].
- rd_data  out  NUM_RD*BITSIZE  read data; port k uses bits [k*BITSIZE +: BITSIZE].
- rd_busy  out  NUM_RD  1 = selected register has an outstanding producer.
- wr0_en  in  1  write port 0 enable (ALU writeback).
- wr0_sel  in  AW  write port 0 register index.
- wr0_data  in  BITSIZE  write port 0 data.
- wr1_en  in  1  write port 1 enable (load writeback).
- wr1_sel  in  AW  write port 1 register index.
- wr1_data  in  BITSIZE  write port 1 data.
- rsv_en  in  1  reserve: mark rsv_sel busy (issue of an instruction with a destination).
- rsv_sel  in  AW  register index to reserve.
- busy_cnt  out  AW+1  number of registers currently busy.

Behaviour:
- Reset (async, any time, including mid-operation):
  - all registers = 0, all busy bits = 0, busy_cnt = 0.
  - rd_data therefore reads 0 and rd_busy reads 0 immediately.
  - writes and reserves in the reset cycle are discarded.
- Storage writes, at posedge clk when not in reset:
  - wrN_en && wrN_sel != ZERO_REG && wrN_sel < REGSIZE writes wrN_data.
  - If both ports target the same register, wr1 wins and wr0 is dropped.
- Reads: combinational, zero latency.
  - rd_sel == ZERO_REG or rd_sel >= REGSIZE -> rd_data = 0 and rd_busy = 0.
  - BYPASS=1: if a write port is enabled for the same register this cycle, rd_data = that port's data (wr1 priority over wr0), otherwise the stored value.
  - BYPASS=0: rd_data = stored value only; the new value appears on the cycle after the write edge.
- Scoreboard, busy[r], updated at posedge clk:
  - Set by rsv_en with rsv_sel = r.
  - Cleared by a qualifying write (either port) to r.
  - Reserve and write to the same r in the same cycle -> busy stays 1 (new producer wins).
  - Reserving an already-busy register (WAW) is legal; the bit stays 1.
  - ZERO_REG and out-of-range indices are never set.
- rd_busy[k]:
  - BYPASS=1: busy[rd_sel_k] && !(any write enabled to rd_sel_k this cycle).
  - BYPASS=0: busy[rd_sel_k] only.
- busy_cnt:
  - Registered; equals the popcount of busy after every edge.
  - Updated incrementally: +1 on a reserve of a non-busy register, -1 per distinct cleared busy register.
  - Two writes to the same register count as one clear.
  - A write and a reserve to the same register give net 0.
  - Range 0..REGSIZE-1, no wrap possible.

Decomposition:
- Package regfile_pkg holds:
  - the default BITSIZE, REGSIZE and ZERO_REG;
  - the AW derivation;
  - the write-port priority constant (WR1_PRIO = 1).
- One natural sub-module, rf_read_port, instantiated NUM_RD times in a generate loop. It performs the zero-register check, the bypass mux and the rd_busy masking for a single port.

Test Plan:
- rst pulsed mid-cycle, asynchronous, after writing R3 = 0xAA and reserving R4 -> rd_data(R3) = 0, rd_busy(R4) = 0 and busy_cnt = 0 before the next clk edge.
- wr0 writes R5 = 0x1111 and wr1 writes R5 = 0x2222 in the same cycle -> afterwards rd_data(R5) = 0x2222; with BYPASS=1 the same-cycle read also shows 0x2222.
- Write R31 = 0xDEAD with ZERO_REG=31, then reserve R31 -> rd_data(R31) = 0, rd_busy = 0, busy_cnt unchanged.
- Reserve R7 in cycle 0, read R7 in cycle 1 -> rd_busy = 1 and busy_cnt = 1. wr1 writes R7 = 0x55 in cycle 2 -> same-cycle rd_busy = 0 and rd_data = 0x55 with BYPASS=1; busy_cnt = 0 after the edge.
- Reserve R8 and wr0 to R8 in the same cycle -> busy stays 1 and busy_cnt is unchanged. Reserve R8 again (WAW) -> busy_cnt does not increment.
- BYPASS=0, NUM_RD=3: write R2 = 0x7 while all three ports read R2 -> all three show the old value that cycle and 0x7 the next cycle.
